threefish1024_unmix: RTL
========================

Name: threefish1024_unmix

Overview:
- Inverse (decrypt-direction) round engine for Threefish-1024 (16 x 64-bit words), the counterpart of the forward MIX datapath.
- Takes one round's output state and undoes it: inverse word permutation, then inverse MIX on the eight word pairs.
- Processes one pair per cycle, reusing a single rotate/subtract datapath.
- Rotation amounts come from the shared rotation-constant lookup, instantiated by the parent and driven through the rot_* ports.

Parameters:
- ROUND_W, 7, width of round index (rounds 0..79).
- WORD_W, 64, word width; only 64 is supported.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- in_valid_i  in  1  input state valid
- in_ready_o  out  1  block can accept input
- state_i  in  1024  round output; word i = state_i[64i+63:64i]
- round_i  in  ROUND_W  forward round index d that produced state_i
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- state_o  out  1024  reconstructed round input, same word order
- rot_d_o  out  3  lookup row index = d[2:0]
- rot_j_o  out  3  lookup column index = current pair j
- rot_amt_i  in  6  rotation amount R(d mod 8, j), combinational from lookup

Behaviour:
- Reset: FSM in IDLE; in_ready_o=1, out_valid_o=0, state_o=0, j=0, rot_d_o=0, rot_j_o=0. Reset wins over every other event, including mid-operation: any partial result is discarded.
- States: IDLE -> UNMIX -> DONE -> IDLE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i & in_ready_o, latch round_i[2:0] and load the un-permuted state y[pi(i)] = v[i].
  - pi = {0,9,2,13,6,11,4,15,10,7,12,3,14,5,8,1}.
  - Set j=0 and go to UNMIX.
- UNMIX:
  - in_ready_o=0; runs exactly 8 cycles, j = 0..7.
  - rot_j_o=j; rot_d_o = latched d[2:0], held constant for the whole operation.
  - Each cycle, with y0 = word 2j and y1 = word 2j+1:
    - x1 = rotr(y1 ^ y0, rot_amt_i)
    - x0 = (y0 - x1) mod 2^64
    - write x0, x1 back to words 2j, 2j+1.
  - Rotation by 0 must be handled correctly (x1 = y1 ^ y0).
  - After j=7, go to DONE.
- DONE:
  - out_valid_o=1; state_o holds the result and stays stable until out_ready_i.
  - in_valid_i is ignored.
  - On out_ready_i, go to IDLE; out_valid_o drops the next cycle.
  - No same-cycle accept of a new input.
- Latency: an input accepted at clock edge T gives out_valid_o=1 after edge T+8. Throughput is at most one state per 10 cycles.
- state_o reflects the working register at all times, but is meaningful only while out_valid_o=1.
- Arithmetic is modulo 2^64; no carries cross word boundaries.
- round_i values of 80 and above are accepted as-is; only bits [2:0] affect the rotation, and bits [1:0] affect the optional subkey step.

Optional Feature:
- Macro: THREEFISH_UNMIX_SUBKEY_EN
- Enabled:
  - Adds input subkey_i [1024], sampled with the input handshake.
  - After UNMIX, if the latched round_i[1:0]==0, one extra SUB state subtracts subkey word-wise (mod 2^64) before DONE; latency becomes 9.
  - Otherwise subkey_i is ignored and latency stays 8.
- Disabled: the port and the SUB state do not exist; latency is always 8.

Test Plan:
- Pair-0 vector: state_i word0=0x1, all other words 0, round_i=0, lookup returns 24 for j=0 -> after 8 cycles word0=0xFFFFFF0000000001, word1=0x0000010000000000, all other words 0.
- All-zero state_i, any round_i -> state_o all zero; out_valid_o rises exactly 8 cycles after accept.
- round_i=13 -> rot_d_o=5 in all 8 UNMIX cycles; rot_j_o steps 0,1,...,7, then the block returns to DONE.
- Back-pressure: out_ready_i=0 for 5 cycles in DONE while in_valid_i=1 -> state_o stable, out_valid_o=1, in_ready_o=0, no new load; out_ready_i=1 -> IDLE next cycle.
- Reset at UNMIX j=4 -> next cycle in_ready_o=1, out_valid_o=0, state_o=0; a following input processes normally.
- SUBKEY_EN: zero state, round_i=4, every subkey word=1 -> all words 0xFFFFFFFFFFFFFFFF after 9 cycles; same stimulus with round_i=5 -> all zero after 8 cycles.

Source files
------------

// File: rtl/threefish1024_unmix.sv
// threefish1024_unmix: inverse Threefish-1024 round engine.
// Undoes one forward round: inverse word permutation on load, then the
// inverse MIX on the eight word pairs, one pair per clock, using a single
// shared rotate/subtract datapath. Rotation amounts come from an external
// lookup addressed through rot_d_o / rot_j_o.
// Optional build macro THREEFISH_UNMIX_SUBKEY_EN adds subkey_i and a SUB
// state that removes the injected subkey on rounds with round_i[1:0]==0.
module threefish1024_unmix #(
    parameter int ROUND_W = 7,
    parameter int WORD_W  = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [16*WORD_W-1:0]  state_i,
    input  logic [ROUND_W-1:0]    round_i,
`ifdef THREEFISH_UNMIX_SUBKEY_EN
    input  logic [16*WORD_W-1:0]  subkey_i,
`endif
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [16*WORD_W-1:0]  state_o,
    output logic [2:0]            rot_d_o,
    output logic [2:0]            rot_j_o,
    input  logic [5:0]            rot_amt_i
);

    // Forward permutation; the load places input word i at position PI[i].
    localparam int PI [16] = '{0, 9, 2, 13, 6, 11, 4, 15, 10, 7, 12, 3, 14, 5, 8, 1};

`ifdef THREEFISH_UNMIX_SUBKEY_EN
    typedef enum logic [1:0] {S_IDLE, S_UNMIX, S_SUB, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_UNMIX, S_DONE} state_t;
`endif

    state_t                r_fsm;
    logic [16*WORD_W-1:0]  r_state;
    logic [2:0]            r_d;
    logic [2:0]            r_j;
    logic                  r_in_ready;
    logic                  r_out_valid;
`ifdef THREEFISH_UNMIX_SUBKEY_EN
    logic [16*WORD_W-1:0]  r_subkey;
    logic [16*WORD_W-1:0]  w_sub;
`endif

    logic [16*WORD_W-1:0]  w_unperm;
    logic [9:0]            w_base_lo;
    logic [9:0]            w_base_hi;
    logic [WORD_W-1:0]     w_y0;
    logic [WORD_W-1:0]     w_y1;
    logic [WORD_W-1:0]     w_xor;
    logic [WORD_W-1:0]     w_x1;
    logic [WORD_W-1:0]     w_x0;
    logic                  w_unused_round;

    // Only the low round bits select rotations; the rest is accepted as-is.
    assign w_unused_round = ^round_i[ROUND_W-1:3];

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = r_out_valid;
    assign state_o     = r_state;
    assign rot_d_o     = r_d;
    assign rot_j_o     = r_j;

    // Undo the word permutation so the pairs line up for the inverse MIX.
    always_comb begin
        w_unperm = '0;
        for (int i = 0; i < 16; i++) begin
            w_unperm[PI[i]*WORD_W +: WORD_W] = state_i[i*WORD_W +: WORD_W];
        end
    end

    // Pair j occupies words 2j and 2j+1, i.e. bit offsets 128j and 128j+64.
    assign w_base_lo = {r_j, 7'd0};
    assign w_base_hi = {r_j, 7'd64};
    assign w_y0      = r_state[w_base_lo +: WORD_W];
    assign w_y1      = r_state[w_base_hi +: WORD_W];
    assign w_xor     = w_y1 ^ w_y0;

    // Rotate right by rot_amt_i; bit k takes bit (k+amt) mod 64, so 0 is a pass-through.
    always_comb begin
        w_x1 = '0;
        for (int k = 0; k < 64; k++) begin
            w_x1[k] = w_xor[6'(k) + rot_amt_i];
        end
    end

    assign w_x0 = w_y0 - w_x1;

`ifdef THREEFISH_UNMIX_SUBKEY_EN
    // Word-wise modular subtraction of the latched subkey.
    always_comb begin
        w_sub = '0;
        for (int i = 0; i < 16; i++) begin
            w_sub[i*WORD_W +: WORD_W] = r_state[i*WORD_W +: WORD_W] - r_subkey[i*WORD_W +: WORD_W];
        end
    end
`endif

    // Control FSM and working state register; reset discards any partial result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fsm       <= S_IDLE;
            r_state     <= '0;
            r_d         <= '0;
            r_j         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
`ifdef THREEFISH_UNMIX_SUBKEY_EN
            r_subkey    <= '0;
`endif
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (in_valid_i && r_in_ready) begin
                        r_state    <= w_unperm;
                        r_d        <= round_i[2:0];
                        r_j        <= '0;
                        r_in_ready <= 1'b0;
`ifdef THREEFISH_UNMIX_SUBKEY_EN
                        r_subkey   <= subkey_i;
`endif
                        r_fsm      <= S_UNMIX;
                    end
                end
                S_UNMIX: begin
                    r_state[w_base_lo +: WORD_W] <= w_x0;
                    r_state[w_base_hi +: WORD_W] <= w_x1;
                    r_j <= r_j + 3'd1;
                    if (r_j == 3'd7) begin
`ifdef THREEFISH_UNMIX_SUBKEY_EN
                        if (r_d[1:0] == 2'd0) begin
                            r_fsm <= S_SUB;
                        end else begin
                            r_fsm       <= S_DONE;
                            r_out_valid <= 1'b1;
                        end
`else
                        r_fsm       <= S_DONE;
                        r_out_valid <= 1'b1;
`endif
                    end
                end
`ifdef THREEFISH_UNMIX_SUBKEY_EN
                S_SUB: begin
                    r_state     <= w_sub;
                    r_out_valid <= 1'b1;
                    r_fsm       <= S_DONE;
                end
`endif
                S_DONE: begin
                    if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_fsm       <= S_IDLE;
                    end
                end
                default: begin
                    r_fsm       <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
